// File: rtl/ks_multiword_add_seq_if.sv
// Bundles the requester handshake, the slice-adder bus and the result
// handshake of the multi-word add/subtract sequencer into one interface.
interface ks_multiword_add_seq_if #(
  parameter int SLICE_W  = 8,
  parameter int N_SLICES = 4
);
  localparam int W = SLICE_W * N_SLICES;

  // Request side
  logic               start;
  logic               in_ready;
  logic               sub;
  logic [W-1:0]       a;
  logic [W-1:0]       b;
  logic               cin;

  // External combinational slice adder
  logic [SLICE_W-1:0] ad_a;
  logic [SLICE_W-1:0] ad_b;
  logic               ad_cin;
  logic               ad_en;
  logic [SLICE_W-1:0] ad_sum;
  logic               ad_cout;

  // Result side
  logic [W-1:0]       result;
  logic               cout;
  logic               ovf;
  logic               out_valid;
  logic               out_ready;

  // Sequencer view
  modport slave (
    input  start, sub, a, b, cin, ad_sum, ad_cout, out_ready,
    output in_ready, ad_a, ad_b, ad_cin, ad_en, result, cout, ovf, out_valid
  );

  // Requester / adder / consumer view
  modport master (
    output start, sub, a, b, cin, ad_sum, ad_cout, out_ready,
    input  in_ready, ad_a, ad_b, ad_cin, ad_en, result, cout, ovf, out_valid
  );
endinterface

// File: rtl/ks_multiword_add_seq.sv
// Wide add/subtract built by time-multiplexing one external SLICE_W-bit
// Kogge-Stone adder over N_SLICES operand slices, LSB slice first. The
// carry between slices lives in r_carry; subtraction is A + ~B + 1.
module ks_multiword_add_seq #(
  parameter int SLICE_W  = 8,
  parameter int N_SLICES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  ks_multiword_add_seq_if.slave bus
);
  localparam int W     = SLICE_W * N_SLICES;
  localparam int IDX_W = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLICES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic               r_sub;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic [W-1:0]       r_result;
  logic               r_cout;
  logic               r_ovf;

  logic               w_accept;
  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_ad_en;
  logic [SLICE_W-1:0] w_ad_a;
  logic [SLICE_W-1:0] w_ad_b;
  logic               w_ad_cin;
  logic               w_last;
  logic               w_ovf_slice;

  logic [SLICE_W-1:0] w_a_slices [N_SLICES];
  logic [SLICE_W-1:0] w_b_slices [N_SLICES];

  // Split the captured operands into per-slice views for the RUN mux
  generate
    for (genvar gi = 0; gi < N_SLICES; gi++) begin : g_slice
      assign w_a_slices[gi] = r_a[gi*SLICE_W +: SLICE_W];
      assign w_b_slices[gi] = r_b[gi*SLICE_W +: SLICE_W];
    end
  endgenerate

  assign w_last = (r_idx == LAST_IDX);

  // Signed overflow is decided on the top slice only: operands (B already
  // inverted for sub) agree in sign but the sum's sign differs.
  assign w_ovf_slice = (w_ad_a[SLICE_W-1] == w_ad_b[SLICE_W-1]) &&
                       (bus.ad_sum[SLICE_W-1] != w_ad_a[SLICE_W-1]);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and state-decoded outputs, adder bus driven only in RUN
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    w_ad_en      = 1'b0;
    w_ad_a       = '0;
    w_ad_b       = '0;
    w_ad_cin     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        w_ad_en  = 1'b1;
        w_ad_a   = w_a_slices[r_idx];
        w_ad_b   = r_sub ? ~w_b_slices[r_idx] : w_b_slices[r_idx];
        w_ad_cin = r_carry;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: capture operands on acceptance, then fold one slice per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a      <= bus.a;
      r_b      <= bus.b;
      r_sub    <= bus.sub;
      r_carry  <= bus.sub ? 1'b1 : bus.cin;
      r_idx    <= '0;
      r_result <= '0;
    end else if (r_state == S_RUN) begin
      for (int i = 0; i < N_SLICES; i++) begin
        if (r_idx == IDX_W'(i)) begin
          r_result[i*SLICE_W +: SLICE_W] <= bus.ad_sum;
        end
      end
      r_carry <= bus.ad_cout;
      if (w_last) begin
        r_cout <= bus.ad_cout;
        r_ovf  <= w_ovf_slice;
        r_idx  <= '0;
      end else begin
        r_idx  <= r_idx + IDX_W'(1);
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.ad_en     = w_ad_en;
  assign bus.ad_a      = w_ad_a;
  assign bus.ad_b      = w_ad_b;
  assign bus.ad_cin    = w_ad_cin;
  assign bus.result    = r_result;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_ks_multiword_add_seq.sv
// Bench for ks_multiword_add_seq: plays the role of requester, consumer and
// external slice adder, and checks against a whole-word arithmetic model.
module tb_ks_multiword_add_seq;
  localparam int SW = 8;
  localparam int NS = 4;
  localparam int W  = SW * NS;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ks_multiword_add_seq_if #(.SLICE_W(SW), .N_SLICES(NS)) bus ();

  ks_multiword_add_seq #(.SLICE_W(SW), .N_SLICES(NS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External combinational slice adder
  assign {bus.ad_cout, bus.ad_sum} = {1'b0, bus.ad_a} + {1'b0, bus.ad_b} + {8'd0, bus.ad_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full operation: accept, watch every slice on the adder bus, check the
  // result timing and value, optionally release it. Called right after a negedge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic c, input logic rel);
    logic [W-1:0] bx;
    logic [W-1:0] exp_res;
    logic [W:0]   full;
    logic [W:0]   part;
    logic [W:0]   mask;
    logic         c0;
    logic         exp_cout;
    logic         exp_ovf;
    bx       = s ? ~b : b;
    c0       = s ? 1'b1 : c;
    full     = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, c0};
    exp_res  = full[W-1:0];
    exp_cout = full[W];
    if (s) exp_ovf = (a[W-1] != b[W-1]) && (exp_res[W-1] != a[W-1]);
    else   exp_ovf = (a[W-1] == b[W-1]) && (exp_res[W-1] != a[W-1]);

    bus.start = 1'b1; bus.a = a; bus.b = b; bus.sub = s; bus.cin = c;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.sub = 1'($urandom); bus.cin = 1'($urandom);

    for (int k = 0; k < NS; k++) begin
      if (k > 0) @(negedge clk);
      mask = (({{W{1'b0}}, 1'b1}) << (k * SW)) - 1;
      part = ({1'b0, a} & mask) + ({1'b0, bx} & mask) + {{W{1'b0}}, c0};
      checks++;
      if (bus.ad_en !== 1'b1) begin
        failures++; $display("FAIL ad_en slice%0d: got %b want 1", k, bus.ad_en);
      end
      checks++;
      if (bus.ad_a !== a[k*SW +: SW]) begin
        failures++; $display("FAIL ad_a slice%0d: got %h want %h", k, bus.ad_a, a[k*SW +: SW]);
      end
      checks++;
      if (bus.ad_b !== bx[k*SW +: SW]) begin
        failures++; $display("FAIL ad_b slice%0d: got %h want %h", k, bus.ad_b, bx[k*SW +: SW]);
      end
      checks++;
      if (bus.ad_cin !== part[k*SW]) begin
        failures++; $display("FAIL ad_cin slice%0d: got %b want %b", k, bus.ad_cin, part[k*SW]);
      end
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
        failures++; $display("FAIL early_valid slice%0d: got valid=%b in_ready=%b want 0/0",
                             k, bus.out_valid, bus.in_ready);
      end
    end

    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.ad_en !== 1'b0) begin
      failures++; $display("FAIL done_flags: got valid=%b in_ready=%b ad_en=%b want 1/0/0",
                           bus.out_valid, bus.in_ready, bus.ad_en);
    end
    checks++;
    if (bus.result !== exp_res || bus.cout !== exp_cout || bus.ovf !== exp_ovf) begin
      failures++; $display("FAIL result: got %h c=%b v=%b want %h c=%b v=%b",
                           bus.result, bus.cout, bus.ovf, exp_res, exp_cout, exp_ovf);
    end
    $display("op a=%h b=%h sub=%0d cin=%0d -> result=%h cout=%0d ovf=%0d",
             a, b, s, c, bus.result, bus.cout, bus.ovf);

    if (rel) begin
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        failures++; $display("FAIL release: got valid=%b in_ready=%b want 0/1",
                             bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.ad_en !== 1'b0) begin
      failures++; $display("FAIL reset_flags: got in_ready=%b valid=%b ad_en=%b want 1/0/0",
                           bus.in_ready, bus.out_valid, bus.ad_en);
    end
    checks++;
    if (bus.result !== '0 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      failures++; $display("FAIL reset_result: got %h c=%b v=%b want 0", bus.result, bus.cout, bus.ovf);
    end
    checks++;
    if (bus.ad_a !== '0 || bus.ad_b !== '0 || bus.ad_cin !== 1'b0) begin
      failures++; $display("FAIL reset_adbus: got a=%h b=%h cin=%b want 0", bus.ad_a, bus.ad_b, bus.ad_cin);
    end
    $display("reset done");
  endtask

  task automatic test_directed();
    run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1'b1);
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1);
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1);
    run_op(32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b1);
    run_op(32'h00000005, 32'h00000007, 1'b1, 1'b1, 1'b1);
    run_op(32'h00000007, 32'h00000005, 1'b1, 1'b0, 1'b1);
    run_op(32'h80000000, 32'h00000001, 1'b1, 1'b0, 1'b1);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      run_op($urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1);
    end
  endtask

  task automatic test_backpressure();
    run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) begin
      bus.start = 1'b1; bus.a = $urandom; bus.b = $urandom; bus.sub = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.ad_en !== 1'b0) begin
        failures++; $display("FAIL bp_flags cyc%0d: got valid=%b in_ready=%b ad_en=%b want 1/0/0",
                             n, bus.out_valid, bus.in_ready, bus.ad_en);
      end
      checks++;
      if (bus.result !== 32'h23456789 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
        failures++; $display("FAIL bp_hold cyc%0d: got %h c=%b v=%b want 23456789 c=0 v=0",
                             n, bus.result, bus.cout, bus.ovf);
      end
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL bp_release: got in_ready=%b valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    $display("backpressure hold of 3 cycles released");
    run_op(32'h00010000, 32'h0000FFFF, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) begin
      run_op($urandom, $urandom, 1'(n), 1'b1, 1'b1);
    end
  endtask

  task automatic test_reset_mid_run();
    bus.start = 1'b1; bus.a = 32'hDEADBEEF; bus.b = 32'hCAFEF00D; bus.sub = 1'b0; bus.cin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.ad_en !== 1'b1 || bus.ad_a !== 8'hAD) begin
      failures++; $display("FAIL abort_slice2: got ad_en=%b ad_a=%h want 1/ad", bus.ad_en, bus.ad_a);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.ad_en !== 1'b0 || bus.result !== '0) begin
      failures++; $display("FAIL abort_state: got in_ready=%b valid=%b ad_en=%b result=%h want 1/0/0/0",
                           bus.in_ready, bus.out_valid, bus.ad_en, bus.result);
    end
    $display("reset during RUN slice 2 discarded operation");
    run_op(32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ks_multiword_add_seq.md
Name: ks_multiword_add_seq

Overview:
- Sequencer that performs a wide add/subtract by time-multiplexing one narrow Kogge-Stone slice adder over successive operand slices, LSB slice first.
- Carry is chained between slices through a carry register.
- Sits between a requester (valid/ready in, valid/ready out) and an external combinational SLICE_W-bit Kogge-Stone adder, which returns sum and carry-out in the same cycle.

Parameters:
- SLICE_W, 8, bit width of the external slice adder.
- N_SLICES, 4, number of slices per operation; W = SLICE_W*N_SLICES (default 32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request valid; accepted when start & in_ready at a clk edge.
- in_ready  output  1  high only in IDLE.
- sub  input  1  0 = A+B+cin, 1 = A-B (cin ignored); sampled at acceptance.
- a  input  W  operand A; sampled at acceptance.
- b  input  W  operand B; sampled at acceptance.
- cin  input  1  carry-in for add; sampled at acceptance.
- ad_a  output  SLICE_W  slice of A presented to the slice adder.
- ad_b  output  SLICE_W  slice of B, or ~B when sub, presented to the slice adder.
- ad_cin  output  1  carry-in to the slice adder.
- ad_en  output  1  high while a slice is being processed (RUN).
- ad_sum  input  SLICE_W  slice adder sum.
- ad_cout  input  1  slice adder carry-out.
- result  output  W  assembled sum/difference.
- cout  output  1  final carry-out; for sub, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.

Behaviour:
- Reset values (rst high at an edge): state IDLE; in_ready=1; out_valid=0; ad_en=0; result=0; cout=0; ovf=0; slice index=0; carry register=0.
- Reset has priority over every other event, including mid-RUN or in DONE. An in-flight operation is discarded with no output.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge → capture a, b, sub into registers; carry register <= (sub ? 1 : cin); index <= 0; result <= 0; go to RUN.
  - start=0 → stay in IDLE.
- RUN: one slice per cycle, k = index.
  - ad_a = A_reg[k*SLICE_W +: SLICE_W].
  - ad_b = B_reg slice k, bitwise inverted when sub_reg.
  - ad_cin = carry register; ad_en = 1.
  - At the edge: result slice k <= ad_sum; carry register <= ad_cout; index <= k+1.
  - When k = N_SLICES-1: cout <= ad_cout; ovf <= (ad_a[MSB] == ad_b[MSB]) & (ad_sum[MSB] != ad_a[MSB]); index wraps to 0; go to DONE.
- Outside RUN: ad_a, ad_b = 0; ad_cin = 0; ad_en = 0.
- DONE:
  - out_valid = 1; result, cout, ovf held stable.
  - out_ready=1 at an edge → IDLE, out_valid drops next cycle.
  - start is ignored in DONE; in_ready = 0.
- Latency: acceptance edge E0 → slices processed at edges E1..E(N_SLICES). out_valid is high in the cycle after E(N_SLICES), i.e. N_SLICES cycles after acceptance. Throughput is one operation per N_SLICES+2 cycles minimum.
- Changes on a, b, sub, cin after acceptance have no effect on the operation in flight.
- N_SLICES=1 is legal: single RUN cycle.
- Arithmetic: result = (A + B + cin) mod 2^W, or (A + ~B + 1) mod 2^W for sub. Carry is never lost between slices.

Test Plan (SLICE_W=8, N_SLICES=4):
- Add a=0x000000FF, b=0x00000001, cin=0 → ad_cin sequence 0,1,0,0; result=0x00000100, cout=0, ovf=0; out_valid asserted exactly 4 cycles after acceptance.
- Add a=0xFFFFFFFF, b=0x00000001, cin=0 → carry ripples through all slices (ad_cin 0,1,1,1); result=0x00000000, cout=1, ovf=0.
- Add a=0x7FFFFFFF, b=0x00000001 → result=0x80000000, cout=0, ovf=1. Add a=0x80000000, b=0x80000000 → result=0, cout=1, ovf=1.
- Sub a=5, b=7 (cin=1, must be ignored) → first ad_cin=1, first ad_b=0xF8; result=0xFFFFFFFE, cout=0, ovf=0. Sub a=7, b=5 → result=2, cout=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while pulsing start with new operands → out_valid and result stay stable, in_ready=0, start is not accepted. Raise out_ready → IDLE and in_ready=1 next cycle; a new start is then accepted normally.
- Assert rst during RUN at slice index 2 → next cycle state IDLE, in_ready=1, out_valid=0, result=0, ad_en=0. A subsequent add of 1+1 yields result=2 with no residue from the aborted operation.
